// File: rtl/ram_burst_read_ctrl.sv
// Burst read sequencer feeding the RAM read-data capture stage.
// Issues one read per cycle and tracks in-flight reads.
module ram_burst_read_ctrl #(
    parameter int ADDR_W          = 8,
    parameter int LEN_W           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_stall,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              err_q, err_d;

    logic              issue;
    logic              can_issue;
    logic              ret_drop;
    logic              ret;
    logic              dec;
    logic              err_set;

    // Classify returned beats: flushed (pre-reset) reads, counted returns, strays
    always_comb begin
        ret_drop  = i_rd_valid && (drop_q != '0);
        ret       = i_rd_valid && (drop_q == '0);
        dec       = ret && (outst_q != '0);
        err_set   = ret && (outst_q == '0);
        can_issue = !i_stall && (outst_q < OMAX);
    end

    // Next-state and issue logic; first read can go out in the accept cycle
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        issue     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (can_issue) begin
                        issue     = 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = i_cmd_addr;
                        addr_d    = i_cmd_addr + ADDR_W'(1);
                        rem_d     = i_cmd_len - LEN_W'(1);
                        if (i_cmd_len == LEN_W'(1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        addr_d  = i_cmd_addr;
                        rem_d   = i_cmd_len;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if ((rem_q != '0) && can_issue) begin
                    issue     = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Finish as soon as the net count reaches zero this cycle
                if (outst_q == OW'(dec)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outstanding-read count, flush count and sticky error
    always_comb begin
        outst_d = outst_q;
        if (issue && !dec) begin
            outst_d = outst_q + OW'(1);
        end else if (!issue && dec) begin
            outst_d = outst_q - OW'(1);
        end
        drop_d = drop_q;
        if (ret_drop) begin
            drop_d = drop_q - OW'(1);
        end
        err_d = err_q | err_set;
    end

    // State registers; reset remembers in-flight reads so their returns are discarded
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            drop_q    <= outst_q - OW'(dec);
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
        end
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ram_burst_read_ctrl.sv
// Directed scoreboard bench for ram_burst_read_ctrl.
// Instance A uses MAX_OUTSTANDING=4, instance B uses 2.
module tb_ram_burst_read_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_cmd_valid, a_cmd_ready, a_stall, a_rd_en, a_rd_valid;
    logic       a_busy, a_done, a_err, a_stray;
    logic [7:0] a_cmd_addr, a_cmd_len, a_rd_addr;
    logic [1:0] a_pipe = '0;
    logic       a_stall_q = 1'b0;

    logic       b_cmd_valid, b_cmd_ready, b_stall, b_rd_en, b_rd_valid;
    logic       b_busy, b_done, b_err;
    logic [7:0] b_cmd_addr, b_cmd_len, b_rd_addr;
    logic [1:0] b_pipe = '0;

    ram_burst_read_ctrl #(.ADDR_W(8), .LEN_W(8), .MAX_OUTSTANDING(4)) u_a (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready),
        .i_cmd_addr(a_cmd_addr), .i_cmd_len(a_cmd_len),
        .i_stall(a_stall), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr),
        .i_rd_valid(a_rd_valid), .o_busy(a_busy), .o_done(a_done),
        .o_err(a_err)
    );

    ram_burst_read_ctrl #(.ADDR_W(8), .LEN_W(8), .MAX_OUTSTANDING(2)) u_b (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready),
        .i_cmd_addr(b_cmd_addr), .i_cmd_len(b_cmd_len),
        .i_stall(b_stall), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr),
        .i_rd_valid(b_rd_valid), .o_busy(b_busy), .o_done(b_done),
        .o_err(b_err)
    );

    // Capture-stage model: beat returns two cycles after its o_rd_en cycle
    always @(posedge clk) begin
        a_pipe    <= {a_pipe[0], a_rd_en};
        b_pipe    <= {b_pipe[0], b_rd_en};
        a_stall_q <= a_stall;
    end
    assign a_rd_valid = a_pipe[1] | a_stray;
    assign b_rd_valid = b_pipe[1];

    logic [7:0] a_exp[$];
    logic [7:0] b_exp[$];
    int a_rd_cyc[$];
    int a_rd_cnt = 0, a_done_cnt = 0, a_done_cyc = 0, a_last_valid = 0;
    int b_rd_cnt = 0, b_ret_cnt = 0, b_done_cnt = 0;
    int b_out = 0, b_max_out = 0, b_run = 0, b_max_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor A: scoreboard pop on each read strobe
    always @(negedge clk) begin
        if (a_rd_en) begin
            a_rd_cnt++;
            a_rd_cyc.push_back(cyc);
            if (a_exp.size() == 0) chk("a_spurious_rd", a_rd_en, 0);
            else chk("a_rd_addr", a_rd_addr, a_exp.pop_front());
            chk("a_rd_while_stall", a_stall_q, 0);
        end
        if (a_rd_valid) a_last_valid = cyc;
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
        end
    end

    // Monitor B: scoreboard plus in-flight and run-length tracking
    always @(negedge clk) begin
        if (b_rd_valid) begin
            b_out--;
            b_ret_cnt++;
        end
        if (b_rd_en) begin
            b_out++;
            b_rd_cnt++;
            b_run++;
            if (b_exp.size() == 0) chk("b_spurious_rd", b_rd_en, 0);
            else chk("b_rd_addr", b_rd_addr, b_exp.pop_front());
        end else begin
            b_run = 0;
        end
        if (b_out > b_max_out) b_max_out = b_out;
        if (b_run > b_max_run) b_max_run = b_run;
        if (b_done) b_done_cnt++;
    end

    task automatic clr_a();
        a_rd_cnt = 0;
        a_done_cnt = 0;
        a_rd_cyc.delete();
    endtask

    task automatic send_a(input logic [7:0] addr, input logic [7:0] len,
                          output int acc);
        logic [7:0] ad;
        chk("a_ready_before_cmd", a_cmd_ready, 1);
        for (int i = 0; i < int'(len); i++) begin
            ad = addr + 8'(i);
            a_exp.push_back(ad);
        end
        a_cmd_valid = 1'b1;
        a_cmd_addr  = addr;
        a_cmd_len   = len;
        @(posedge clk);
        #1;
        acc = cyc;
        a_cmd_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (a_done_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, a_done_cnt, 1);
        chk({tag, "_exp_empty"}, a_exp.size(), 0);
        chk({tag, "_busy"}, a_busy, 0);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ready"}, a_cmd_ready, 1);
        chk({tag, "_rd_en"}, a_rd_en, 0);
        chk({tag, "_rd_addr"}, a_rd_addr, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_err"}, a_err, 0);
    endtask

    initial begin
        int acc;
        int n;
        logic [7:0] ad;
        rst = 1'b1;
        a_cmd_valid = 0; a_cmd_addr = 0; a_cmd_len = 0;
        a_stall = 0; a_stray = 0;
        b_cmd_valid = 0; b_cmd_addr = 0; b_cmd_len = 0; b_stall = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_a("rst");
        chk("rst_b_ready", b_cmd_ready, 1);
        @(posedge clk);
        #1;

        // 1: basic burst
        clr_a();
        send_a(8'h10, 8'd3, acc);
        wait_done_a("t1");
        chk("t1_rd_cnt", a_rd_cnt, 3);
        for (int i = 0; i < 3; i++) chk("t1_rd_cyc", a_rd_cyc[i], acc + i);
        chk("t1_done_lat", a_done_cyc, a_last_valid + 1);
        chk("t1_err", a_err, 0);

        // 2: address wrap
        clr_a();
        send_a(8'hFE, 8'd4, acc);
        wait_done_a("t2");
        chk("t2_rd_cnt", a_rd_cnt, 4);
        chk("t2_err", a_err, 0);

        // 3: outstanding limit of 2 on instance B
        for (int i = 0; i < 8; i++) begin
            ad = 8'h20 + 8'(i);
            b_exp.push_back(ad);
        end
        b_cmd_valid = 1; b_cmd_addr = 8'h20; b_cmd_len = 8'd8;
        @(posedge clk);
        #1 b_cmd_valid = 0;
        n = 0;
        while (b_done_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t3_done_cnt", b_done_cnt, 1);
        chk("t3_rd_cnt", b_rd_cnt, 8);
        chk("t3_ret_cnt", b_ret_cnt, 8);
        chk("t3_max_outst", b_max_out, 2);
        chk("t3_max_run", b_max_run, 2);
        chk("t3_exp_empty", b_exp.size(), 0);
        chk("t3_err", b_err, 0);

        // 4: stall during ISSUE
        clr_a();
        send_a(8'h30, 8'd6, acc);
        @(posedge clk);
        #1 a_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 a_stall = 1'b0;
        wait_done_a("t4");
        chk("t4_rd_cnt", a_rd_cnt, 6);
        chk("t4_first", a_rd_cyc[0], acc);
        chk("t4_span", a_rd_cyc[5] - a_rd_cyc[0], 8);

        // 5: empty burst
        clr_a();
        send_a(8'h50, 8'd0, acc);
        @(negedge clk);
        chk("t5_done", a_done, 1);
        chk("t5_ready_low", a_cmd_ready, 0);
        @(negedge clk);
        chk("t5_ready_back", a_cmd_ready, 1);
        chk("t5_done_low", a_done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_rd_cnt", a_rd_cnt, 0);
        chk("t5_done_cnt", a_done_cnt, 1);

        // 6: stray return, then reset mid-burst, then a fresh burst
        a_stray = 1'b1;
        @(posedge clk);
        #1 a_stray = 1'b0;
        @(negedge clk);
        chk("t6_err_set", a_err, 1);
        repeat (3) @(negedge clk);
        chk("t6_err_held", a_err, 1);
        @(posedge clk);
        #1;
        clr_a();
        send_a(8'h60, 8'd5, acc);
        n = 0;
        while (a_rd_cnt < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("t6_two_issued", a_rd_cnt >= 2, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        a_exp.delete();
        @(negedge clk);
        chk_reset_a("t6_rst");
        repeat (5) @(negedge clk);
        chk("t6_flush_err", a_err, 0);
        @(posedge clk);
        #1;
        clr_a();
        send_a(8'h70, 8'd2, acc);
        wait_done_a("t6_new");
        chk("t6_new_rd_cnt", a_rd_cnt, 2);
        chk("t6_new_first", a_rd_cyc[0], acc);
        chk("t6_new_err", a_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
